shift_reg_univ: RTL and testbench

Parametrised universal shift register; successor to the fixed 4-bit serial-in/serial-out chain. Provides hold, shift-up, shift-down and parallel load, both serial outputs and complementary parallel outputs. Adds a burst engine that shifts a programmed bit count autonomously with busy/done handshake. Used as the serializer/deserializer building block in datapath and test blocks.

---
 rtl/shift_reg_pkg.sv | 15 +
 rtl/shift_reg_cell.sv | 31 +++
 rtl/shift_reg_univ.sv | 114 +++++++++++
 tb/tb_shift_reg_univ.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared constants for the universal shift register: mode encodings and FSM states.
package shift_reg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_reg_cell.sv
// One bit of the universal shift register: a flop behind a hold/up/down/load mux.
module shift_reg_cell
  import shift_reg_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] sel,
  input  logic       up_in,
  input  logic       dn_in,
  input  logic       ld_in,
  output logic       q
);

  logic r_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_q <= 1'b0;
    end else begin
      case (sel)
        MODE_UP:   r_q <= up_in;
        MODE_DOWN: r_q <= dn_in;
        MODE_LOAD: r_q <= ld_in;
        default:   r_q <= r_q;
      endcase
    end
  end

  assign q = r_q;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register with manual hold/up/down/load and an autonomous burst engine.
// Optional macro SHIFT_REG_UNIV_ROTATE_EN adds a rot input that recirculates the shifted-out bit.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_lo,
  input  logic             sin_hi,
  input  logic [WIDTH-1:0] pin,
  input  logic             start,
  input  logic             dir,
  input  logic [CW-1:0]    nbits,
`ifdef SHIFT_REG_UNIV_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout_hi,
  output logic             sout_lo,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  // Handshake: start is sampled only in IDLE; busy is high for every BURST cycle
  // (one shift each); done pulses for exactly one cycle in DONE, where start is dropped.

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_dir;
  logic [1:0]      w_sel;
  logic            w_up_ser;
  logic            w_dn_ser;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_up_vec;
  logic [WIDTH-1:0] w_dn_vec;
  logic [CW-1:0]   w_nbits_sat;

  assign w_nbits_sat = (nbits > CW'(WIDTH)) ? CW'(WIDTH) : nbits;

`ifdef SHIFT_REG_UNIV_ROTATE_EN
  assign w_up_ser = rot ? w_q[WIDTH-1] : sin_lo;
  assign w_dn_ser = rot ? w_q[0]       : sin_hi;
`else
  assign w_up_ser = sin_lo;
  assign w_dn_ser = sin_hi;
`endif

  assign w_up_vec = {w_q[WIDTH-2:0], w_up_ser};
  assign w_dn_vec = {w_dn_ser, w_q[WIDTH-1:1]};

  // The start edge itself never shifts; a burst shifts only while in BURST.
  always_comb begin
    w_sel = MODE_HOLD;
    case (r_state)
      ST_IDLE: begin
        if (!start && en) w_sel = mode;
      end
      ST_BURST: w_sel = r_dir ? MODE_DOWN : MODE_UP;
      default:  w_sel = MODE_HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_dir   <= dir;
            r_cnt   <= w_nbits_sat;
            r_state <= (w_nbits_sat == '0) ? ST_DONE : ST_BURST;
          end
        end
        ST_BURST: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    shift_reg_cell u_cell (
      .clk   (clk),
      .clr   (clr),
      .sel   (w_sel),
      .up_in (w_up_vec[i]),
      .dn_in (w_dn_vec[i]),
      .ld_in (pin[i]),
      .q     (w_q[i])
    );
  end

  assign q         = w_q;
  assign qbar      = ~w_q;
  assign sout_hi   = w_q[WIDTH-1];
  assign sout_lo   = w_q[0];
  assign busy      = (r_state == ST_BURST);
  assign done      = (r_state == ST_DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ (WIDTH=4): manual modes, bursts, edge cases and async reset.
module tb_shift_reg_univ;

  localparam int WIDTH = 4;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk;
  logic             clr;
  logic             en;
  logic [1:0]       mode;
  logic             sin_lo;
  logic             sin_hi;
  logic [WIDTH-1:0] pin;
  logic             start;
  logic             dir;
  logic [CW-1:0]    nbits;
  logic             rot;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             sout_hi;
  logic             sout_lo;
  logic             busy;
  logic             done;
  logic [1:0]       dbg_state;

  int checks   = 0;
  int failures = 0;

  shift_reg_univ #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .clr       (clr),
    .en        (en),
    .mode      (mode),
    .sin_lo    (sin_lo),
    .sin_hi    (sin_hi),
    .pin       (pin),
    .start     (start),
    .dir       (dir),
    .nbits     (nbits),
`ifdef SHIFT_REG_UNIV_ROTATE_EN
    .rot       (rot),
`endif
    .q         (q),
    .qbar      (qbar),
    .sout_hi   (sout_hi),
    .sout_lo   (sout_lo),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] up_seq_in [4];
  logic [3:0] up_seq_q  [4];

  initial begin
    rot    = 1'b0;
    clr    = 1'b1;
    en     = 1'b0;
    mode   = 2'b00;
    sin_lo = 1'b0;
    sin_hi = 1'b0;
    pin    = '0;
    start  = 1'b0;
    dir    = 1'b0;
    nbits  = '0;
    #12;
    check("rst_q", q, 4'h0);
    check("rst_qbar", qbar, 4'hF);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    clr = 1'b0;

    // manual shift up: serial-in/serial-out equivalence
    up_seq_in = '{4'd1, 4'd0, 4'd1, 4'd0};
    up_seq_q  = '{4'h1, 4'h2, 4'h5, 4'hA};
    en = 1'b1;
    mode = 2'b01;
    for (int i = 0; i < 4; i++) begin
      sin_lo = up_seq_in[i][0];
      tick();
      check($sformatf("up_q%0d", i), q, up_seq_q[i]);
    end
    check("up_sout_hi", sout_hi, 1);
    check("up_sout_lo", sout_lo, 0);

    // load then shift down, then hold
    pin = 4'hC; mode = 2'b11;
    tick();
    check("load_q", q, 4'hC);
    mode = 2'b10; sin_hi = 1'b1;
    tick();
    check("down_q", q, 4'hE);
    en = 1'b0;
    tick();
    check("hold_q", q, 4'hE);

    // burst up by 3 from 0001 with mode/en toggling
    en = 1'b1; mode = 2'b11; pin = 4'h1;
    tick();
    check("pre_burst_q", q, 4'h1);
    start = 1'b1; dir = 1'b0; nbits = 3'd3; sin_lo = 1'b0;
    tick();
    check("burst_start_q", q, 4'h1);
    check("burst_start_busy", busy, 1);
    start = 1'b0; en = 1'b1; mode = 2'b11; pin = 4'hF;
    tick();
    check("burst_q1", q, 4'h2);
    check("burst_busy1", busy, 1);
    mode = 2'b10; en = 1'b0;
    tick();
    check("burst_q2", q, 4'h4);
    check("burst_busy2", busy, 1);
    en = 1'b1; mode = 2'b11;
    tick();
    check("burst_q3", q, 4'h8);
    check("burst_done", done, 1);
    check("burst_done_busy", busy, 0);
    tick();
    check("burst_after_done", done, 0);
    check("burst_after_q", q, 4'h8);
    en = 1'b0;

    // nbits = 0: straight to DONE, q unchanged; start held through DONE is dropped
    start = 1'b1; nbits = 3'd0;
    tick();
    check("n0_done", done, 1);
    check("n0_busy", busy, 0);
    check("n0_q", q, 4'h8);
    tick();
    check("n0_state_idle", dbg_state, 0);
    check("n0_done_low", done, 0);
    start = 1'b0;
    tick();
    check("n0_no_rearm", dbg_state, 0);
    check("n0_q_after", q, 4'h8);

    // nbits = 7 saturates to 4 shifts
    start = 1'b1; dir = 1'b0; nbits = 3'd7; sin_lo = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("sat_q3", q, 4'h7);
    check("sat_busy3", busy, 1);
    tick();
    check("sat_q4", q, 4'hF);
    check("sat_done", done, 1);
    tick();
    check("sat_idle_q", q, 4'hF);

    // reset in the middle of a down burst
    en = 1'b1; mode = 2'b11; pin = 4'hB;
    tick();
    en = 1'b0;
    start = 1'b1; dir = 1'b1; nbits = 3'd3; sin_hi = 1'b0;
    tick();
    start = 1'b0;
    check("mid_busy_before", busy, 1);
    check("mid_q_before", q, 4'hB);
    #2;
    clr = 1'b1;
    #1;
    check("mid_rst_q", q, 4'h0);
    check("mid_rst_qbar", qbar, 4'hF);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    clr = 1'b0;
    tick();
    check("mid_no_done1", done, 0);
    tick();
    check("mid_no_done2", done, 0);
    check("mid_state_idle", dbg_state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
